gpu_ram_sdp: RTL and testbench
==============================

Name: gpu_ram_sdp

Overview:
- Parametrised simple-dual-port RAM for GPU-side storage: one write port with byte enables and one read port, on a single clock.
- Next-generation replacement for the single-port LPM-style RAM.
- Adds independent read/write addressing, a selectable output register, a defined read-during-write policy, read-valid tracking, out-of-range detection, and an optional hardware clear after reset.
- Sits between shader-core load/store logic and on-chip memory.

Parameters:
- WORD_WIDTH, 32, bits per word; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane.
- ADDRESS_WIDTH, 10, address port width.
- WORD_COUNT, 1<<ADDRESS_WIDTH, words stored; must satisfy 2^(ADDRESS_WIDTH-1) < WORD_COUNT <= 2^ADDRESS_WIDTH.
- OUT_REG, 1, 1 = extra output register stage (read latency 2); 0 = latency 1.
- RDW_NEW_DATA, 0, same-address read-during-write: 0 = return old data, 1 = return newly merged data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- busy  out  1  high while the clear sequence runs; all requests are ignored.
- wr_en  in  1  write request.
- wr_address  in  ADDRESS_WIDTH  write word address.
- wr_data  in  WORD_WIDTH  write data.
- wr_byteen  in  WORD_WIDTH/BYTE_WIDTH  per-lane write enable; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_address  in  ADDRESS_WIDTH  read word address.
- rd_data  out  WORD_WIDTH  read data.
- rd_valid  out  1  rd_data holds the result of a read request.
- range_error  out  1  sticky; set by any accepted request with address >= WORD_COUNT.

Behaviour:
- Reset (async assert, sync deassert use):
  - busy = CLEAR_ON_RESET; rd_valid = 0; rd_data = 0; range_error = 0.
  - State = CLEAR if CLEAR_ON_RESET, else READY.
  - Clear counter = 0.
  - Memory array is not reset asynchronously.
- States:
  - CLEAR: write zero to word[counter], counter++. At counter == WORD_COUNT-1, write it, then move to READY next cycle; busy falls in that same transition.
    - Duration: exactly WORD_COUNT cycles after reset release.
  - READY: requests accepted every cycle. No stalls, no backpressure.
- Requests during busy: wr_en/rd_en ignored, no memory change, rd_valid stays 0, range_error not updated.
- Reset asserted mid-clear: returns to CLEAR with counter = 0; full clear repeats.
- Write: on a clock edge with wr_en & !busy & wr_address < WORD_COUNT, each lane with wr_byteen[i] = 1 takes wr_data's lane; other lanes keep their value. wr_byteen = 0 is a legal no-op.
- Read:
  - rd_en & !busy samples rd_address at the edge.
  - OUT_REG = 0: rd_data/rd_valid update one edge later.
  - OUT_REG = 1: two edges later. The intermediate stage carries its own valid bit.
  - Fully pipelined: back-to-back reads return in order, one per cycle.
- rd_valid is high for exactly one cycle per accepted read. rd_data holds its last value when rd_valid = 0.
- Out of range (address >= WORD_COUNT):
  - Write is dropped.
  - Read returns all zeros with rd_valid = 1.
  - range_error is set and cleared only by reset.
- Same-address read and write in one cycle:
  - RDW_NEW_DATA = 0: read returns the pre-write word.
  - RDW_NEW_DATA = 1: read returns the byte-merged result, i.e. enabled lanes from wr_data, others from the old word.
- Different addresses: fully independent.
- Elaboration check: illegal parameter combinations stop elaboration via $fatal in an initial block.

Decomposition:
- Shared package gpu_ram_pkg:
  - state enum {RAM_CLEAR, RAM_READY}
  - function merge_bytes(old, new, byteen) parametrised by widths via localparams in the instance
  - localparam helpers for lane count
- One natural sub-module: gpu_ram_out_pipe, the 0/1-stage output register with valid, selected by OUT_REG.
- The core array plus CLEAR FSM stay in gpu_ram_sdp.

Test Plan:
- Clear: WORD_COUNT=16, CLEAR_ON_RESET=1, memory preloaded 0xFFFFFFFF, reset released -> busy high exactly 16 cycles; subsequent reads of all 16 addresses return 0x00000000; rd_valid 0 during busy despite rd_en = 1.
- Byte enables: write 0x11223344 to addr 5 with byteen 4'b1111, then 0xAABBCCDD with byteen 4'b0101 -> read addr 5 returns 0x11BB33DD.
- Latency: OUT_REG=1, reads of addr 1,2,3 on consecutive cycles -> rd_valid high on cycles +2,+3,+4 with the matching data. OUT_REG=0 -> cycles +1,+2,+3.
- Read-during-write: addr 7 holds 0x0; same cycle write 0xDEADBEEF (byteen 4'b1100) and read addr 7 -> RDW_NEW_DATA=0 returns 0x00000000; RDW_NEW_DATA=1 returns 0xDEAD0000.
- Range: WORD_COUNT=12, ADDRESS_WIDTH=4, write 0x5 to addr 13 then read addr 13 -> rd_data 0, rd_valid 1, range_error 1 and stays 1; addr 0–11 contents unchanged.
- Mid-clear reset: WORD_COUNT=16, reset_n pulsed low at clear cycle 6 -> busy stays high 16 further cycles after release; all words read 0.

Source files
------------

// File: rtl/gpu_ram_pkg.sv
// Shared types and helpers for the GPU simple-dual-port RAM.
package gpu_ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Widest word the merge helper handles; callers pad narrower words up to it.
  localparam int MAX_WORD_WIDTH = 256;
  localparam int MAX_LANES      = MAX_WORD_WIDTH;

  function automatic int lane_count(input int word_width, input int byte_width);
    return word_width / byte_width;
  endfunction

  // Enabled lanes take new_word, the rest keep old_word.
  function automatic logic [MAX_WORD_WIDTH-1:0] merge_bytes(
    input logic [MAX_WORD_WIDTH-1:0] old_word,
    input logic [MAX_WORD_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      byteen,
    input int                        byte_width
  );
    logic [MAX_WORD_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_WORD_WIDTH; b++) begin
      if (byteen[b / byte_width]) merged[b] = new_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/gpu_ram_out_pipe.sv
// Optional output register stage with its own valid bit.
// OUT_REG = 0 is a straight wire-through.
module gpu_ram_out_pipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (OUT_REG != 0) begin : g_reg
    // second stage: valid follows every cycle, data holds between reads
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end
  end else begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/gpu_ram_sdp.sv
// Simple-dual-port GPU RAM: byte-enabled write port, pipelined read port,
// optional zero sweep after reset, sticky out-of-range flag.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RAM_CLEAR | zeroing word[clear_count]; busy high, requests ignored
// RAM_READY | normal traffic, one read and one write accepted per cycle
module gpu_ram_sdp
  import gpu_ram_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 10,
  parameter int WORD_COUNT     = 1 << ADDRESS_WIDTH,
  parameter int OUT_REG        = 1,
  parameter int RDW_NEW_DATA   = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             busy,
  input  logic                             wr_en,
  input  logic [ADDRESS_WIDTH-1:0]         wr_address,
  input  logic [WORD_WIDTH-1:0]            wr_data,
  input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] wr_byteen,
  input  logic                             rd_en,
  input  logic [ADDRESS_WIDTH-1:0]         rd_address,
  output logic [WORD_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             range_error
);

  localparam int LANES = lane_count(WORD_WIDTH, BYTE_WIDTH);
  localparam logic [ADDRESS_WIDTH:0]   ADDR_LIMIT  = (ADDRESS_WIDTH+1)'(WORD_COUNT);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(WORD_COUNT - 1);
  localparam ram_state_t               RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;

  // Illegal parameter sets stop elaboration.
  if (BYTE_WIDTH < 1 || WORD_WIDTH < BYTE_WIDTH || (WORD_WIDTH % BYTE_WIDTH) != 0
      || WORD_WIDTH > MAX_WORD_WIDTH) begin : g_bad_width
    $fatal(1, "gpu_ram_sdp: WORD_WIDTH must be a multiple of BYTE_WIDTH and <= %0d", MAX_WORD_WIDTH);
  end
  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 30 || WORD_COUNT > (1 << ADDRESS_WIDTH)
      || WORD_COUNT <= (1 << (ADDRESS_WIDTH - 1))) begin : g_bad_depth
    $fatal(1, "gpu_ram_sdp: WORD_COUNT must lie in (2^(ADDRESS_WIDTH-1), 2^ADDRESS_WIDTH]");
  end
  if (OUT_REG < 0 || OUT_REG > 1 || RDW_NEW_DATA < 0 || RDW_NEW_DATA > 1
      || CLEAR_ON_RESET < 0 || CLEAR_ON_RESET > 1) begin : g_bad_flag
    $fatal(1, "gpu_ram_sdp: OUT_REG, RDW_NEW_DATA and CLEAR_ON_RESET must be 0 or 1");
  end

  ram_state_t               state, state_next;
  logic [ADDRESS_WIDTH-1:0] clear_count;
  logic                     clear_last;

  logic [WORD_WIDTH-1:0]    mem [WORD_COUNT];

  logic                     wr_accept, rd_accept;
  logic                     wr_in_range, rd_in_range, wr_hit;
  logic [WORD_WIDTH-1:0]    old_word, merged_word, rd_word_next, rd_word;
  logic                     rd_word_valid;

  assign clear_last  = (clear_count == LAST_ADDR);
  assign wr_accept   = wr_en & ~busy;
  assign rd_accept   = rd_en & ~busy;
  assign wr_in_range = ({1'b0, wr_address} < ADDR_LIMIT);
  assign rd_in_range = ({1'b0, rd_address} < ADDR_LIMIT);
  assign wr_hit      = wr_accept & wr_in_range & (wr_address == rd_address);

  // state register and clear sweep address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_STATE;
      clear_count <= '0;
    end else begin
      state <= state_next;
      if (state == RAM_CLEAR && !clear_last) clear_count <= clear_count + ADDRESS_WIDTH'(1);
    end
  end

  // leave CLEAR on the edge that zeroes the last word
  always_comb begin
    state_next = state;
    case (state)
      RAM_CLEAR: if (clear_last) state_next = RAM_READY;
      RAM_READY: state_next = RAM_READY;
      default:   state_next = RESET_STATE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = 1'b0;
    if (state == RAM_CLEAR) busy = 1'b1;
  end

  // array write port: zero sweep while busy, byte-lane writes once ready
  always_ff @(posedge clock) begin
    if (busy) begin
      mem[clear_count] <= '0;
    end else if (wr_accept && wr_in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_byteen[i]) mem[wr_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign old_word    = mem[rd_address];
  assign merged_word = WORD_WIDTH'(merge_bytes(MAX_WORD_WIDTH'(old_word), MAX_WORD_WIDTH'(wr_data),
                                               MAX_LANES'(wr_byteen), BYTE_WIDTH));

  // read word selection: out-of-range reads as zero, optional write bypass
  always_comb begin
    rd_word_next = old_word;
    if (!rd_in_range) rd_word_next = '0;
    else if (RDW_NEW_DATA != 0 && wr_hit) rd_word_next = merged_word;
  end

  // first read stage: registered array read with its own valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_word_valid <= 1'b0;
      rd_word       <= '0;
    end else begin
      rd_word_valid <= rd_accept;
      if (rd_accept) rd_word <= rd_word_next;
    end
  end

  // sticky flag for any accepted access beyond the populated depth
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_error <= 1'b0;
    end else if ((wr_accept && !wr_in_range) || (rd_accept && !rd_in_range)) begin
      range_error <= 1'b1;
    end
  end

  gpu_ram_out_pipe #(
    .WIDTH   (WORD_WIDTH),
    .OUT_REG (OUT_REG)
  ) u_out_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rd_word_valid),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_gpu_ram_sdp.sv
// Two RAM configurations driven with the same traffic and checked against
// an array-based reference that tracks contents, clear time and read latency.
module tb_gpu_ram_sdp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [3:0]  wr_address, rd_address, wr_byteen;
  logic [31:0] wr_data;

  logic        busy_a, rd_valid_a, range_error_a;
  logic [31:0] rd_data_a;
  logic        busy_b, rd_valid_b, range_error_b;
  logic [31:0] rd_data_b;

  always #5 clock = ~clock;

  // a: 12 words, two-cycle latency, old data on collision
  gpu_ram_sdp #(
    .WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDRESS_WIDTH(4), .WORD_COUNT(12),
    .OUT_REG(1), .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .busy(busy_a),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_byteen(wr_byteen),
    .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .range_error(range_error_a)
  );

  // b: 16 words, one-cycle latency, merged data on collision
  gpu_ram_sdp #(
    .WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDRESS_WIDTH(4), .WORD_COUNT(16),
    .OUT_REG(0), .RDW_NEW_DATA(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .busy(busy_b),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_byteen(wr_byteen),
    .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .range_error(range_error_b)
  );

  int wc  [2] = '{12, 16};
  int lat [2] = '{2, 1};
  int rdw [2] = '{0, 1};

  logic [31:0] ref_mem    [2][16];
  int          clear_left [2];
  logic        ref_rerr   [2];
  logic        hist_v     [2][2];
  logic [31:0] hist_d     [2][2];
  logic [31:0] ref_rd_data[2];

  int    checks = 0;
  int    passes = 0;
  string phase  = "init";

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_dut(input int d, input logic b, input logic v, input logic [31:0] rd,
                           input logic re);
    check($sformatf("%s dut%0d busy", phase, d), 32'(b), 32'(clear_left[d] > 0));
    check($sformatf("%s dut%0d rd_valid", phase, d), 32'(v), 32'(hist_v[d][lat[d]-1]));
    check($sformatf("%s dut%0d rd_data", phase, d), rd, ref_rd_data[d]);
    check($sformatf("%s dut%0d range_error", phase, d), 32'(re), 32'(ref_rerr[d]));
  endtask

  task automatic check_all();
    check_dut(0, busy_a, rd_valid_a, rd_data_a, range_error_a);
    check_dut(1, busy_b, rd_valid_b, rd_data_b, range_error_b);
  endtask

  // reference behaviour for one rising edge, using the inputs held across it
  task automatic model_edge();
    if (!reset_n) return;
    for (int d = 0; d < 2; d++) begin
      logic        acc;
      logic [31:0] res;
      acc = 1'b0;
      res = 32'h0;
      if (clear_left[d] > 0) begin
        clear_left[d]--;
        if (clear_left[d] == 0) for (int a = 0; a < 16; a++) ref_mem[d][a] = 32'h0;
      end else begin
        if (rd_en) begin
          acc = 1'b1;
          if (int'(rd_address) >= wc[d]) begin
            ref_rerr[d] = 1'b1;
          end else begin
            res = ref_mem[d][rd_address];
            if (rdw[d] == 1 && wr_en && wr_address == rd_address) res = merge(res, wr_data, wr_byteen);
          end
        end
        if (wr_en) begin
          if (int'(wr_address) >= wc[d]) ref_rerr[d] = 1'b1;
          else ref_mem[d][wr_address] = merge(ref_mem[d][wr_address], wr_data, wr_byteen);
        end
      end
      hist_v[d][1] = hist_v[d][0];
      hist_d[d][1] = hist_d[d][0];
      hist_v[d][0] = acc;
      hist_d[d][0] = res;
      if (hist_v[d][lat[d]-1]) ref_rd_data[d] = hist_d[d][lat[d]-1];
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
    wr_en = we; wr_address = wa; wr_data = wd; wr_byteen = be;
    rd_en = re; rd_address = ra;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic apply_reset(input int edges);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      clear_left[d]  = wc[d];
      ref_rerr[d]    = 1'b0;
      ref_rd_data[d] = 32'h0;
      for (int k = 0; k < 2; k++) begin
        hist_v[d][k] = 1'b0;
        hist_d[d][k] = 32'h0;
      end
    end
    check_all();
    repeat (edges) step();
    reset_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 16; a++) drive(1'b1, 4'(a), $urandom | 32'h1, 4'hF, 1'b0, 4'h0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(3);
  endtask

  initial begin
    reset_n = 1'b1;
    wr_en = 1'b0; wr_address = 4'h0; wr_data = 32'h0; wr_byteen = 4'h0;
    rd_en = 1'b0; rd_address = 4'h0;
    @(negedge clock);

    phase = "reset";
    apply_reset(3);

    phase = "clear";
    repeat (18) drive(1'b1, 4'($urandom_range(0, 11)), $urandom, 4'hF, 1'b1, 4'($urandom_range(0, 11)));
    idle(2);
    read_all();

    phase = "byteen";
    drive(1'b1, 4'd5, 32'h11223344, 4'b1111, 1'b0, 4'h0);
    drive(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'h0);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd5);
    idle(3);
    check("byteen word a", rd_data_a, 32'h11BB33DD);
    check("byteen word b", rd_data_b, 32'h11BB33DD);

    phase = "latency";
    for (int a = 1; a <= 3; a++) drive(1'b1, 4'(a), 32'h100 + 32'(a), 4'hF, 1'b0, 4'h0);
    for (int a = 1; a <= 3; a++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(3);
    check("latency last a", rd_data_a, 32'h103);

    phase = "rdw";
    drive(1'b1, 4'd7, 32'h0, 4'hF, 1'b0, 4'h0);
    drive(1'b1, 4'd7, 32'hDEADBEEF, 4'b1100, 1'b1, 4'd7);
    idle(3);
    check("rdw old a", rd_data_a, 32'h00000000);
    check("rdw new b", rd_data_b, 32'hDEAD0000);

    phase = "range";
    drive(1'b1, 4'd13, 32'h5, 4'hF, 1'b0, 4'h0);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd13);
    idle(3);
    check("range data a", rd_data_a, 32'h0);
    check("range flag a", 32'(range_error_a), 32'h1);
    read_all();

    phase = "random";
    repeat (400) drive(1'($urandom), 4'($urandom), $urandom, 4'($urandom),
                       1'($urandom), 4'($urandom));
    idle(3);

    phase = "reclear";
    fill_random();
    apply_reset(2);
    idle(17);
    read_all();

    phase = "midclear";
    fill_random();
    apply_reset(2);
    idle(6);
    apply_reset(1);
    repeat (18) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'($urandom_range(0, 11)));
    idle(2);
    read_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
